// File: rtl/tiny1_memsys_pkg.sv
// Shared address map, control-bit indices and return-selector encoding for tiny1_memsys.
package tiny1_memsys_pkg;

  localparam int unsigned DATA_W = 16;

  localparam logic [15:0] MMIO_BASE    = 16'h4000;
  localparam logic [15:0] REG_IRQ_PEND = 16'hFFF0;
  localparam logic [15:0] REG_IRQ_MASK = 16'hFFF2;
  localparam logic [15:0] REG_TMR_CNT  = 16'hFFF4;
  localparam logic [15:0] REG_TMR_CMP  = 16'hFFF6;
  localparam logic [15:0] REG_TMR_CTL  = 16'hFFF8;

  // Word offsets inside the register window (byte address bits [3:1])
  localparam logic [2:0] OFF_PEND = 3'(REG_IRQ_PEND >> 1);
  localparam logic [2:0] OFF_MASK = 3'(REG_IRQ_MASK >> 1);
  localparam logic [2:0] OFF_CNT  = 3'(REG_TMR_CNT >> 1);
  localparam logic [2:0] OFF_CMP  = 3'(REG_TMR_CMP >> 1);
  localparam logic [2:0] OFF_CTL  = 3'(REG_TMR_CTL >> 1);

  localparam int unsigned CTL_EN = 0;
  localparam int unsigned CTL_AR = 1;

  typedef enum logic [1:0] {
    SEL_RAM = 2'd0,
    SEL_REG = 2'd1,
    SEL_EXT = 2'd2
  } sel_e;

endpackage

// File: rtl/tiny1_irq_timer.sv
// Interrupt controller and free-running timer: source synchronizers, pending/mask,
// counter/compare and the registered register read port.
module tiny1_irq_timer
  import tiny1_memsys_pkg::*;
#(
  parameter int unsigned NIRQ = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr,
  input  logic              rd,
  input  logic [2:0]        off,
  input  logic [DATA_W-1:0] wdata,
  input  logic [NIRQ-2:0]   irq_src,
  input  logic              irqack,
  output logic [DATA_W-1:0] rdata,
  output logic              irq
);

  logic [NIRQ-2:0]   sync1, sync2, hist, rise;
  logic [NIRQ-1:0]   pend, mask, set_v, clr_v;
  logic [DATA_W-1:0] cnt, cmp, rd_mux;
  logic [1:0]        ctl;
  logic              match;

  assign match = ctl[CTL_EN] && (cnt == cmp);
  assign set_v = {rise, match};
  assign clr_v = (wr && off == OFF_PEND) ? wdata[NIRQ-1:0] : '0;
  assign irq   = (|(pend & mask)) & ~irqack;

  always_comb begin
    rd_mux = '0;
    case (off)
      OFF_PEND: rd_mux = DATA_W'(pend);
      OFF_MASK: rd_mux = DATA_W'(mask);
      OFF_CNT:  rd_mux = cnt;
      OFF_CMP:  rd_mux = cmp;
      OFF_CTL:  rd_mux = DATA_W'(ctl);
      default:  rd_mux = '0;
    endcase
  end

  // Edge detect is registered so a source reaches pending three edges after sampling
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1 <= '0;
      sync2 <= '0;
      hist  <= '0;
      rise  <= '0;
      pend  <= '0;
      mask  <= '0;
      cnt   <= '0;
      cmp   <= '1;
      ctl   <= '0;
      rdata <= '0;
    end else begin
      sync1 <= irq_src;
      sync2 <= sync1;
      hist  <= sync2;
      rise  <= sync2 & ~hist;
      pend  <= (pend & ~clr_v) | set_v;
      if (wr && off == OFF_MASK) mask <= wdata[NIRQ-1:0];
      if (wr && off == OFF_CNT)
        cnt <= wdata;
      else if (ctl[CTL_EN])
        cnt <= (match && ctl[CTL_AR]) ? '0 : cnt + DATA_W'(1);
      if (wr && off == OFF_CMP) cmp <= wdata;
      if (wr && off == OFF_CTL) ctl <= wdata[1:0];
      if (rd) rdata <= rd_mux;
    end
  end

endmodule

// File: rtl/tiny1_memsys.sv
// tiny1 memory subsystem: synchronous RAM, MMIO decode, external I/O port and
// registered read-return mux in front of the IRQ/timer block.
module tiny1_memsys
  import tiny1_memsys_pkg::*;
#(
  parameter int unsigned RAM_WORDS = 8192,
  parameter int unsigned NIRQ      = 8,
  parameter string       INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       mem_addr,
  input  logic [DATA_W-1:0] mem_data_i,
  input  logic              mem_wr,
  input  logic              mem_rd,
  output logic [DATA_W-1:0] mem_data_o,
  output logic [DATA_W-1:0] ram_data_o,
  output logic              irq,
  input  logic              irqack,
  input  logic [NIRQ-2:0]   irq_src,
  output logic [14:0]       io_addr,
  output logic [DATA_W-1:0] io_wdata,
  output logic              io_wr,
  output logic              io_rd,
  input  logic [DATA_W-1:0] io_rdata
);

  localparam int unsigned AW = $clog2(RAM_WORDS);

  logic [DATA_W-1:0] ram [RAM_WORDS];
  logic [DATA_W-1:0] ram_q, reg_rdata;
  logic [AW-1:0]     ram_idx;
  logic              is_ram, is_reg, is_ext;
  sel_e              sel, sel_d;

  // Address bit 0 is don't-care, so the register window spans FFF0..FFF9
  assign is_ram  = mem_addr < MMIO_BASE;
  assign is_reg  = (mem_addr >= REG_IRQ_PEND) && (mem_addr <= (REG_TMR_CTL | 16'h0001));
  assign is_ext  = ~is_ram & ~is_reg;
  assign ram_idx = mem_addr[AW:1];

  assign io_addr  = mem_addr[15:1];
  assign io_wdata = mem_data_i;
  assign io_wr    = mem_wr & is_ext;
  assign io_rd    = mem_rd & is_ext;

  // Read-first: the registered read sees the word before a same-edge write
  always_ff @(posedge clk) begin
    if (mem_wr && is_ram) ram[ram_idx] <= mem_data_i;
  end

  always_ff @(posedge clk) begin
    if (!rst) ram_q <= '0;
    else      ram_q <= ram[ram_idx];
  end

  assign ram_data_o = ram_q;

  always_comb begin
    sel_d = SEL_EXT;
    if (is_ram)      sel_d = SEL_RAM;
    else if (is_reg) sel_d = SEL_REG;
  end

  always_ff @(posedge clk) begin
    if (!rst)        sel <= SEL_RAM;
    else if (mem_rd) sel <= sel_d;
  end

  always_comb begin
    mem_data_o = '0;
    case (sel)
      SEL_RAM: mem_data_o = ram_q;
      SEL_REG: mem_data_o = reg_rdata;
      SEL_EXT: mem_data_o = io_rdata;
      default: mem_data_o = '0;
    endcase
  end

  tiny1_irq_timer #(.NIRQ(NIRQ)) u_irq_timer (
    .clk     (clk),
    .rst     (rst),
    .wr      (mem_wr & is_reg),
    .rd      (mem_rd & is_reg),
    .off     (mem_addr[3:1]),
    .wdata   (mem_data_i),
    .irq_src (irq_src),
    .irqack  (irqack),
    .rdata   (reg_rdata),
    .irq     (irq)
  );

endmodule

// File: tb/tb_tiny1_memsys.sv
// Self-checking bench for tiny1_memsys: directed stimulus, a cycle model of the
// memory map / interrupt / timer rules, and hand-computed literal checkpoints.
module tb_tiny1_memsys;

  localparam int unsigned NIRQ = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] mem_addr, mem_data_i, mem_data_o, ram_data_o, io_wdata, io_rdata;
  logic        mem_wr, mem_rd, irq, irqack, io_wr, io_rd;
  logic [NIRQ-2:0] irq_src;
  logic [14:0] io_addr;

  int n_tests = 0;
  int n_fail  = 0;
  bit started = 1'b0;

  tiny1_memsys #(.RAM_WORDS(8192), .NIRQ(NIRQ), .INIT_FILE("")) dut (
    .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_data_i(mem_data_i),
    .mem_wr(mem_wr), .mem_rd(mem_rd), .mem_data_o(mem_data_o),
    .ram_data_o(ram_data_o), .irq(irq), .irqack(irqack), .irq_src(irq_src),
    .io_addr(io_addr), .io_wdata(io_wdata), .io_wr(io_wr), .io_rd(io_rd),
    .io_rdata(io_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // 0 = RAM, 1 = internal register, 2 = external port
  function automatic int region(input logic [15:0] a);
    if (a < 16'h4000) return 0;
    if (a >= 16'hFFF0 && a <= 16'hFFF9) return 1;
    return 2;
  endfunction

  // ---------------- behavioural model ----------------
  logic [15:0] m_ram [int];
  logic [15:0] m_pend, m_mask, m_cnt, m_cmp;
  logic [1:0]  m_ctl;
  logic [NIRQ-2:0] smp [5];
  logic [15:0] e_ram, e_mdo;
  bit          e_ram_ok, e_mdo_ok, e_mdo_ext;

  function automatic logic [15:0] reg_val(input logic [2:0] off);
    case (off)
      3'd0: return m_pend;
      3'd1: return m_mask;
      3'd2: return m_cnt;
      3'd3: return m_cmp;
      3'd4: return {14'd0, m_ctl};
      default: return 16'h0000;
    endcase
  endfunction

  always @(posedge clk) begin
    automatic int          w    = int'(mem_addr[13:1]);
    automatic int          rg   = region(mem_addr);
    automatic logic [2:0]  off  = mem_addr[3:1];
    automatic bit          wreg = mem_wr && rg == 1;
    automatic bit          hit;
    automatic logic [15:0] clr;
    automatic logic [NIRQ-2:0] rise;
    if (!rst) begin
      started   = 1'b1;
      m_pend    = 16'h0;  m_mask = 16'h0;  m_cnt = 16'h0;
      m_cmp     = 16'hFFFF;  m_ctl = 2'b00;
      for (int i = 0; i < 5; i++) smp[i] = '0;
      e_ram     = 16'h0;  e_ram_ok = 1'b1;
      e_mdo     = 16'h0;  e_mdo_ok = 1'b1;  e_mdo_ext = 1'b0;
    end else if (started) begin
      e_ram_ok = m_ram.exists(w);
      if (e_ram_ok) e_ram = m_ram[w];
      e_mdo_ok  = mem_rd;
      e_mdo_ext = mem_rd && rg == 2;
      if (mem_rd && rg == 0) begin e_mdo = e_ram; e_mdo_ok = e_ram_ok; end
      if (mem_rd && rg == 1) e_mdo = reg_val(off);
      // a level seen at edge t sets pending at edge t+3 when it was low at t-1
      for (int i = 4; i > 0; i--) smp[i] = smp[i-1];
      smp[0] = irq_src;
      rise = smp[3] & ~smp[4];
      hit  = m_ctl[0] && (m_cnt == m_cmp);
      clr  = (wreg && off == 3'd0) ? mem_data_i : 16'h0;
      m_pend = ((m_pend & ~clr) | 16'({rise, hit})) & 16'h00FF;
      if (wreg && off == 3'd2)  m_cnt = mem_data_i;
      else if (m_ctl[0])        m_cnt = (hit && m_ctl[1]) ? 16'h0 : m_cnt + 16'd1;
      if (wreg && off == 3'd1)  m_mask = mem_data_i & 16'h00FF;
      if (wreg && off == 3'd3)  m_cmp  = mem_data_i;
      if (wreg && off == 3'd4)  m_ctl  = mem_data_i[1:0];
    end
    if (mem_wr && rg == 0) m_ram[w] = mem_data_i;
  end

  always @(negedge clk) begin
    if (started) begin
      if (e_ram_ok) chk("ram_data_o", ram_data_o, e_ram);
      if (e_mdo_ok) chk("mem_data_o", mem_data_o, e_mdo_ext ? io_rdata : e_mdo);
      chk("irq", 16'(irq), 16'((|(m_pend & m_mask)) & ~irqack));
      chk("io_wr", 16'(io_wr), 16'(mem_wr && region(mem_addr) == 2));
      chk("io_rd", 16'(io_rd), 16'(mem_rd && region(mem_addr) == 2));
      chk("io_addr", 16'(io_addr), 16'(mem_addr[15:1]));
      chk("io_wdata", io_wdata, mem_data_i);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    mem_addr = a; mem_data_i = d; mem_wr = 1'b1;
    step();
    mem_wr = 1'b0;
  endtask

  task automatic rd_chk(input string nm, input logic [15:0] a, input logic [15:0] e);
    mem_addr = a; mem_rd = 1'b1;
    step();
    chk(nm, mem_data_o, e);
    mem_rd = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; mem_addr = 16'h0; mem_data_i = 16'h0; mem_wr = 1'b0; mem_rd = 1'b0;
    irqack = 1'b0; irq_src = '0; io_rdata = 16'h0;
    repeat (3) step();
    chk("reset_mdo", mem_data_o, 16'h0000);
    chk("reset_irq", 16'(irq), 16'h0);
    rst = 1'b1;
    rd_chk("reset_cmp", 16'hFFF6, 16'hFFFF);

    // RAM write, read, read-first collision
    wr(16'h0100, 16'h1234);
    rd_chk("ram_rd", 16'h0100, 16'h1234);
    chk("ram_raw", ram_data_o, 16'h1234);
    mem_addr = 16'h0100; mem_data_i = 16'hBEEF; mem_wr = 1'b1; mem_rd = 1'b1;
    step();
    chk("ram_rd_first", mem_data_o, 16'h1234);
    mem_wr = 1'b0; mem_rd = 1'b0;
    rd_chk("ram_rd_new", 16'h0100, 16'hBEEF);

    // External port
    wr(16'h0002, 16'h5555);
    mem_addr = 16'h4002; mem_rd = 1'b1;
    #1;
    chk("ext_io_rd", 16'(io_rd), 16'h1);
    chk("ext_io_addr", 16'(io_addr), 16'h2001);
    step();
    io_rdata = 16'hA5A5;
    #1;
    chk("ext_rdata", mem_data_o, 16'hA5A5);
    mem_rd = 1'b0; mem_data_i = 16'h7777; mem_wr = 1'b1;
    #1;
    chk("ext_io_wr", 16'(io_wr), 16'h1);
    step();
    mem_wr = 1'b0;
    rd_chk("ext_no_ram", 16'h0002, 16'h5555);

    // Source interrupt, ack masking, W1C
    wr(16'hFFF2, 16'h0002);
    irq_src = 7'b0000001; step(); irq_src = '0;
    step(); step();
    chk("irq_early", 16'(irq), 16'h0);
    step();
    chk("irq_src_set", 16'(irq), 16'h1);
    rd_chk("pend_src", 16'hFFF0, 16'h0002);
    irqack = 1'b1; #1;
    chk("irq_acked", 16'(irq), 16'h0);
    wr(16'hFFF0, 16'h0002);
    irqack = 1'b0; #1;
    chk("irq_cleared", 16'(irq), 16'h0);
    rd_chk("pend_w1c", 16'hFFF0, 16'h0000);

    // W1C colliding with a new edge on the same bit
    irq_src = 7'b0000001; step(); irq_src = '0;
    repeat (4) step();
    rd_chk("pend_pre", 16'hFFF0, 16'h0002);
    irq_src = 7'b0000001; step(); irq_src = '0;
    step(); step();
    wr(16'hFFF0, 16'h0002);
    rd_chk("set_beats_w1c", 16'hFFF0, 16'h0002);
    wr(16'hFFF0, 16'h0002);
    rd_chk("pend_clr2", 16'hFFF0, 16'h0000);

    // Timer with auto-reload, then without
    wr(16'hFFF2, 16'h0001);
    wr(16'hFFF6, 16'h0005);
    wr(16'hFFF8, 16'h0003);
    repeat (5) step();
    chk("tmr_pre", 16'(irq), 16'h0);
    step();
    chk("tmr_irq", 16'(irq), 16'h1);
    rd_chk("cnt_reload", 16'hFFF4, 16'h0000);
    wr(16'hFFF8, 16'h0000);
    wr(16'hFFF0, 16'h0001);
    wr(16'hFFF4, 16'h0000);
    wr(16'hFFF8, 16'h0001);
    repeat (6) step();
    chk("tmr_irq2", 16'(irq), 16'h1);
    rd_chk("cnt_continue", 16'hFFF4, 16'h0006);

    // Reset mid-operation with a source held high across release
    irq_src = 7'b0000010;
    rst = 1'b0;
    step();
    chk("rst_irq", 16'(irq), 16'h0);
    chk("rst_mdo", mem_data_o, 16'h0000);
    step();
    rst = 1'b1;
    rd_chk("rst_cnt", 16'hFFF4, 16'h0000);
    rd_chk("rst_cmp", 16'hFFF6, 16'hFFFF);
    rd_chk("rst_ctl", 16'hFFF8, 16'h0000);
    rd_chk("rst_mask", 16'hFFF2, 16'h0000);
    step();
    rd_chk("rst_src_pend", 16'hFFF0, 16'h0004);
    rd_chk("ram_retained", 16'h0100, 16'hBEEF);
    irq_src = '0;
    repeat (3) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
